spu_pipe_stage_reg: RTL and testbench

Parametrised dual-issue pipeline stage register, successor to the fixed REG→EX latch. It carries LANES instruction slots with valid/ready flow control and a 2-entry skid buffer, so downstream backpressure never combinationally reaches upstream. It adds pipeline flush, per-lane squash and a stall counter. The same block is instantiated at every stage boundary from REG→EX onward.

---
 rtl/spu_pipe_pkg.sv | 24 ++
 rtl/spu_skid_slot.sv | 47 ++++
 rtl/spu_pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_spu_pipe_stage_reg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pipe_pkg.sv
// Shared widths and per-lane payload layout for the SPU pipeline stage registers.
// Module width parameters default to these constants; lane fields are sized by them.
package spu_pipe_pkg;

    localparam int SPU_LANES  = 2;
    localparam int SPU_DATA_W = 128;
    localparam int SPU_ADDR_W = 7;
    localparam int SPU_CTRL_W = 4;
    localparam int SPU_IMM_W  = 18;
    localparam int SPU_CNT_W  = 16;

    typedef struct packed {
        logic                  reg_wr_en;
        logic                  source;
        logic [SPU_CTRL_W-1:0] control;
        logic [SPU_DATA_W-1:0] data_ra;
        logic [SPU_DATA_W-1:0] data_rb;
        logic [SPU_DATA_W-1:0] data_rc;
        logic [SPU_ADDR_W-1:0] addr_ra;
        logic [SPU_ADDR_W-1:0] addr_rb;
        logic [SPU_IMM_W-1:0]  imm;
    } lane_payload_t;

endpackage

// File: rtl/spu_skid_slot.sv
// One storage entry (payload + valid) of the stage register.
// Latency: load visible the cycle after the edge. No flow control of its own; flush beats load and clear.
module spu_skid_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic         vld_q;
    logic         vld_d;
    logic [W-1:0] dat_q;

    always_comb begin
        vld_d = vld_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            vld_d = 1'b1;
        end else if (clear_i) begin
            vld_d = 1'b0;
        end
    end

    // Payload is only zeroed by reset; a flushed entry keeps stale data behind a cleared valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (load_i && !flush_i) begin
                dat_q <= d_i;
            end
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/spu_pipe_stage_reg.sv
// Multi-lane pipeline stage register with a 2-entry skid buffer, flush, lane squash and stall counter.
// Latency: 1 cycle; 1 beat/cycle sustained. in_ready comes from SKID state only, so out_ready never reaches upstream.
module spu_pipe_stage_reg
    import spu_pipe_pkg::*;
#(
    parameter int LANES  = SPU_LANES,
    parameter int DATA_W = SPU_DATA_W,
    parameter int ADDR_W = SPU_ADDR_W,
    parameter int CTRL_W = SPU_CTRL_W,
    parameter int IMM_W  = SPU_IMM_W,
    parameter int CNT_W  = SPU_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [LANES-1:0]        lane_kill,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_reg_wr_en,
    input  logic [LANES-1:0]        in_source,
    input  logic [LANES*CTRL_W-1:0] in_control,
    input  logic [LANES*DATA_W-1:0] in_data_ra,
    input  logic [LANES*DATA_W-1:0] in_data_rb,
    input  logic [LANES*DATA_W-1:0] in_data_rc,
    input  logic [LANES*ADDR_W-1:0] in_addr_ra,
    input  logic [LANES*ADDR_W-1:0] in_addr_rb,
    input  logic [LANES*IMM_W-1:0]  in_imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_reg_wr_en,
    output logic [LANES-1:0]        out_source,
    output logic [LANES*CTRL_W-1:0] out_control,
    output logic [LANES*DATA_W-1:0] out_data_ra,
    output logic [LANES*DATA_W-1:0] out_data_rb,
    output logic [LANES*DATA_W-1:0] out_data_rc,
    output logic [LANES*ADDR_W-1:0] out_addr_ra,
    output logic [LANES*ADDR_W-1:0] out_addr_rb,
    output logic [LANES*IMM_W-1:0]  out_imm,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int PW = LANES * $bits(lane_payload_t);

    lane_payload_t [LANES-1:0] in_pl;
    lane_payload_t [LANES-1:0] out_pl;
    logic [PW-1:0]             main_d;
    logic [PW-1:0]             main_dat;
    logic [PW-1:0]             skid_dat;
    logic                      main_vld;
    logic                      skid_vld;
    logic                      accept;
    logic                      pop;
    logic                      main_free;
    logic                      main_load;
    logic                      main_clear;
    logic                      skid_load;
    logic                      skid_clear;
    logic [CNT_W-1:0]          stall_cnt_q;
    logic [CNT_W-1:0]          stall_cnt_d;

    always_comb begin
        in_pl = '0;
        for (int i = 0; i < LANES; i++) begin
            in_pl[i].reg_wr_en = in_reg_wr_en[i] & ~lane_kill[i];
            in_pl[i].source    = in_source[i];
            in_pl[i].control   = in_control[i*CTRL_W +: CTRL_W];
            in_pl[i].data_ra   = in_data_ra[i*DATA_W +: DATA_W];
            in_pl[i].data_rb   = in_data_rb[i*DATA_W +: DATA_W];
            in_pl[i].data_rc   = in_data_rc[i*DATA_W +: DATA_W];
            in_pl[i].addr_ra   = in_addr_ra[i*ADDR_W +: ADDR_W];
            in_pl[i].addr_rb   = in_addr_rb[i*ADDR_W +: ADDR_W];
            in_pl[i].imm       = in_imm[i*IMM_W +: IMM_W];
        end
    end

    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign accept    = in_valid && in_ready;
    assign pop       = main_vld && out_ready;
    assign main_free = !main_vld || pop;

    // An occupied SKID forces in_ready low, so a SKID->MAIN refill never races an accept.
    assign main_load  = (pop && skid_vld) || (accept && main_free);
    assign main_d     = skid_vld ? skid_dat : in_pl;
    assign main_clear = pop && !main_load;
    assign skid_load  = accept && !main_free;
    assign skid_clear = pop && skid_vld;

    spu_skid_slot #(.W(PW)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (main_load),
        .clear_i (main_clear),
        .flush_i (flush),
        .d_i     (main_d),
        .vld_o   (main_vld),
        .dat_o   (main_dat)
    );

    spu_skid_slot #(.W(PW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .flush_i (flush),
        .d_i     (in_pl),
        .vld_o   (skid_vld),
        .dat_o   (skid_dat)
    );

    assign occupancy = {main_vld & skid_vld, main_vld ^ skid_vld};

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_vld && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign out_pl    = main_dat;

    always_comb begin
        out_reg_wr_en = '0;
        out_source    = '0;
        out_control   = '0;
        out_data_ra   = '0;
        out_data_rb   = '0;
        out_data_rc   = '0;
        out_addr_ra   = '0;
        out_addr_rb   = '0;
        out_imm       = '0;
        for (int i = 0; i < LANES; i++) begin
            out_reg_wr_en[i]                 = out_pl[i].reg_wr_en;
            out_source[i]                    = out_pl[i].source;
            out_control[i*CTRL_W +: CTRL_W]  = out_pl[i].control;
            out_data_ra[i*DATA_W +: DATA_W]  = out_pl[i].data_ra;
            out_data_rb[i*DATA_W +: DATA_W]  = out_pl[i].data_rb;
            out_data_rc[i*DATA_W +: DATA_W]  = out_pl[i].data_rc;
            out_addr_ra[i*ADDR_W +: ADDR_W]  = out_pl[i].addr_ra;
            out_addr_rb[i*ADDR_W +: ADDR_W]  = out_pl[i].addr_rb;
            out_imm[i*IMM_W +: IMM_W]        = out_pl[i].imm;
        end
    end

endmodule

// File: tb/tb_spu_pipe_stage_reg.sv
// Bench for spu_pipe_stage_reg: vector table plus scoreboard of accepted beats.
module tb_spu_pipe_stage_reg;

    localparam int L   = 2;
    localparam int DW  = 128;
    localparam int AW  = 7;
    localparam int CW  = 4;
    localparam int IW  = 18;
    localparam int CNW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [L-1:0]    lane_kill;
    logic            in_valid;
    logic            in_ready;
    logic [L-1:0]    in_reg_wr_en, in_source;
    logic [L*CW-1:0] in_control;
    logic [L*DW-1:0] in_data_ra, in_data_rb, in_data_rc;
    logic [L*AW-1:0] in_addr_ra, in_addr_rb;
    logic [L*IW-1:0] in_imm;
    logic            out_valid;
    logic            out_ready;
    logic [L-1:0]    out_reg_wr_en, out_source;
    logic [L*CW-1:0] out_control;
    logic [L*DW-1:0] out_data_ra, out_data_rb, out_data_rc;
    logic [L*AW-1:0] out_addr_ra, out_addr_rb;
    logic [L*IW-1:0] out_imm;
    logic [1:0]      occupancy;
    logic [CNW-1:0]  stall_cnt;

    always #5 clk = ~clk;

    spu_pipe_stage_reg #(.LANES(L), .DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .IMM_W(IW), .CNT_W(CNW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .lane_kill(lane_kill),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_wr_en(in_reg_wr_en), .in_source(in_source), .in_control(in_control),
        .in_data_ra(in_data_ra), .in_data_rb(in_data_rb), .in_data_rc(in_data_rc),
        .in_addr_ra(in_addr_ra), .in_addr_rb(in_addr_rb), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_wr_en(out_reg_wr_en), .out_source(out_source), .out_control(out_control),
        .out_data_ra(out_data_ra), .out_data_rb(out_data_rb), .out_data_rc(out_data_rc),
        .out_addr_ra(out_addr_ra), .out_addr_rb(out_addr_rb), .out_imm(out_imm),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [L-1:0]    rwe;
        logic [L-1:0]    src;
        logic [L*CW-1:0] ctl;
        logic [L*DW-1:0] ra, rb, rc;
        logic [L*AW-1:0] aa, ab;
        logic [L*IW-1:0] imm;
    } beat_t;

    typedef struct {
        bit       v;
        bit       r;
        bit       f;
        bit [1:0] k;
        bit [1:0] rwe;
        int       occ;
    } vec_t;

    beat_t          sb[$];
    logic [CNW-1:0] stall_m;
    int             checks = 0;
    int             errors = 0;
    int             tag    = 1;
    vec_t           tbl[25];

    function automatic beat_t make_beat(int t, logic [1:0] rwe);
        beat_t       b;
        logic [31:0] u;
        u     = t;
        b.rwe = rwe;
        b.src = u[1:0];
        b.ctl = {u[3:0] ^ 4'h5, u[3:0]};
        b.ra  = {96'h0, u ^ 32'hffff0000, 96'h0, u};
        b.rb  = {8{u * 32'h9e3779b9}};
        b.rc  = {u, ~u, u + 32'd1, ~(u + 32'd1), u + 32'd2, ~(u + 32'd2), u + 32'd3, ~(u + 32'd3)};
        b.aa  = {7'(u + 32'd1), 7'(u)};
        b.ab  = {7'(~u), 7'(u + 32'd3)};
        b.imm = {18'(u * 32'd7), 18'(u * 32'd3 + 32'd5)};
        return b;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 256'(out_valid), 256'(sb.size() > 0));
        chk("in_ready", 256'(in_ready), 256'(sb.size() < 2));
        chk("occupancy", 256'(occupancy), 256'(sb.size()));
        chk("stall_cnt", 256'(stall_cnt), 256'(stall_m));
        if (sb.size() > 0) begin
            chk("reg_wr_en", 256'(out_reg_wr_en), 256'(sb[0].rwe));
            chk("source", 256'(out_source), 256'(sb[0].src));
            chk("control", 256'(out_control), 256'(sb[0].ctl));
            chk("data_ra", 256'(out_data_ra), 256'(sb[0].ra));
            chk("data_rb", 256'(out_data_rb), 256'(sb[0].rb));
            chk("data_rc", 256'(out_data_rc), 256'(sb[0].rc));
            chk("addr_ra", 256'(out_addr_ra), 256'(sb[0].aa));
            chk("addr_rb", 256'(out_addr_rb), 256'(sb[0].ab));
            chk("imm", 256'(out_imm), 256'(sb[0].imm));
        end
    endtask

    task automatic check_zero_payload();
        chk("rst_reg_wr_en", 256'(out_reg_wr_en), 256'(0));
        chk("rst_source", 256'(out_source), 256'(0));
        chk("rst_control", 256'(out_control), 256'(0));
        chk("rst_data_ra", 256'(out_data_ra), 256'(0));
        chk("rst_data_rb", 256'(out_data_rb), 256'(0));
        chk("rst_data_rc", 256'(out_data_rc), 256'(0));
        chk("rst_addr_ra", 256'(out_addr_ra), 256'(0));
        chk("rst_addr_rb", 256'(out_addr_rb), 256'(0));
        chk("rst_imm", 256'(out_imm), 256'(0));
    endtask

    // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
    task automatic cycle(input bit v, input bit r, input bit f, input bit [1:0] k,
                         input bit [1:0] rwe, input int exp_occ);
        beat_t b;
        bit    acc;
        bit    pop;
        b            = make_beat(tag, rwe);
        in_reg_wr_en = b.rwe;
        in_source    = b.src;
        in_control   = b.ctl;
        in_data_ra   = b.ra;
        in_data_rb   = b.rb;
        in_data_rc   = b.rc;
        in_addr_ra   = b.aa;
        in_addr_rb   = b.ab;
        in_imm       = b.imm;
        in_valid     = v;
        out_ready    = r;
        flush        = f;
        lane_kill    = k;
        #3;
        check_outputs();
        if (exp_occ >= 0) chk("table_occ", 256'(occupancy), 256'(exp_occ));
        acc = v && (sb.size() < 2);
        pop = (sb.size() > 0) && r;
        if ((sb.size() > 0) && !r && (stall_m != {CNW{1'b1}})) stall_m = stall_m + 1'b1;
        @(posedge clk);
        if (f) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (acc) begin
                b.rwe = b.rwe & ~k;
                sb.push_back(b);
            end
        end
        if (acc) tag++;
        #1;
    endtask

    initial begin
        tbl = '{
            '{1, 1, 0, 2'b00, 2'b11, 0}, '{1, 1, 0, 2'b00, 2'b01, 1}, '{1, 1, 0, 2'b00, 2'b10, 1},
            '{1, 1, 0, 2'b00, 2'b11, 1}, '{1, 0, 0, 2'b00, 2'b11, 1}, '{1, 0, 0, 2'b00, 2'b11, 2},
            '{0, 0, 0, 2'b00, 2'b11, 2}, '{0, 1, 0, 2'b00, 2'b11, 2}, '{1, 1, 0, 2'b00, 2'b11, 1},
            '{0, 1, 0, 2'b00, 2'b11, 1}, '{0, 1, 0, 2'b00, 2'b11, 0}, '{1, 0, 0, 2'b10, 2'b11, 0},
            '{0, 0, 0, 2'b11, 2'b11, 1}, '{0, 1, 0, 2'b00, 2'b11, 1}, '{1, 0, 0, 2'b00, 2'b11, 0},
            '{1, 0, 0, 2'b00, 2'b11, 1}, '{1, 0, 1, 2'b00, 2'b11, 2}, '{1, 0, 0, 2'b00, 2'b11, 0},
            '{1, 1, 1, 2'b00, 2'b11, 1}, '{0, 1, 0, 2'b00, 2'b11, 0}, '{1, 0, 0, 2'b00, 2'b11, 0},
            '{1, 0, 0, 2'b00, 2'b11, 1}, '{1, 1, 0, 2'b00, 2'b11, 2}, '{1, 1, 0, 2'b00, 2'b11, 1},
            '{0, 1, 0, 2'b00, 2'b11, 1}
        };
        stall_m      = '0;
        reset        = 1'b1;
        flush        = 1'b0;
        lane_kill    = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_reg_wr_en = '0;
        in_source    = '0;
        in_control   = '0;
        in_data_ra   = '0;
        in_data_rb   = '0;
        in_data_rc   = '0;
        in_addr_ra   = '0;
        in_addr_rb   = '0;
        in_imm       = '0;
        #2;
        check_outputs();
        check_zero_payload();
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            cycle(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].k, tbl[i].rwe, tbl[i].occ);
        end

        // Stall counter saturation with a beat parked in MAIN.
        cycle(1, 0, 0, 2'b00, 2'b11, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 2'b00, 2'b11, 1);
        chk("stall_saturated", 256'(stall_cnt), 256'({CNW{1'b1}}));
        cycle(0, 1, 0, 2'b00, 2'b11, 1);
        cycle(0, 1, 0, 2'b00, 2'b11, 0);

        // Asynchronous reset in the middle of a cycle with both entries held.
        cycle(1, 0, 0, 2'b00, 2'b11, 0);
        cycle(1, 0, 0, 2'b00, 2'b11, 1);
        chk("pre_reset_occ", 256'(occupancy), 256'(2));
        #2 reset = 1'b1;
        #1;
        sb.delete();
        stall_m = '0;
        check_outputs();
        check_zero_payload();
        @(posedge clk);
        #1 reset = 1'b0;
        cycle(1, 1, 0, 2'b00, 2'b11, 0);
        cycle(1, 1, 0, 2'b00, 2'b01, 1);
        cycle(0, 1, 0, 2'b00, 2'b11, 1);
        cycle(0, 1, 0, 2'b00, 2'b11, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
